// File: rtl/div_unit.sv
// Restoring 8-bit divider: one quotient bit per clock, signed or unsigned, START/DONE handshake.
// Capture edge, WIDTH CALC edges, then one FIX edge. Divide-by-zero completes on the edge after capture.
module div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed_op,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_prem;
  logic [CW-1:0]    r_cnt;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_dz_pend;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic             w_zero;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  assign w_zero = (i_data2 == '0);
  assign w_neg1 = i_signed_op & i_data1[WIDTH-1];
  assign w_neg2 = i_signed_op & i_data2[WIDTH-1];
  assign w_abs1 = w_neg1 ? -i_data1 : i_data1;
  assign w_abs2 = w_neg2 ? -i_data2 : i_data2;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Kept partial remainders are always below the divisor, so only the shifted value needs the extra bit.
  assign w_shift = {r_prem, r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = w_zero ? FIX : CALC;
      CALC:    if (w_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_dz_pend   <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_prem    <= '0;
            r_dz_pend <= w_zero;
            r_dvs     <= w_abs2;
            r_qsign   <= w_neg1 ^ w_neg2;
            r_rsign   <= w_neg1;
            // Divide-by-zero returns the raw dividend as remainder, so keep it unmodified.
            r_dvd     <= w_zero ? i_data1 : w_abs1;
          end
        end
        CALC: begin
          r_cnt  <= r_cnt + CW'(1);
          r_prem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_dvd  <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
        end
        FIX: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_div_zero <= r_dz_pend;
          if (r_dz_pend) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd;
          end else begin
            r_quotient  <= r_qsign ? -r_dvd : r_dvd;
            r_remainder <= r_rsign ? -r_prem : r_prem;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor pops on DONE.
module tb_div_unit;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sop   = 1'b0;
  logic [7:0] d1    = '0;
  logic [7:0] d2    = '0;
  logic [7:0] o_quotient;
  logic [7:0] o_remainder;
  logic       o_busy;
  logic       o_done;
  logic       o_div_zero;

  div_unit #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_signed_op (sop),
    .i_data1     (d1),
    .i_data2     (d2),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_div_zero  (o_div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
  } vec_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; SV int '/' truncates toward zero and '%' follows the dividend.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s, input int cap);
    exp_t e;
    int   x;
    int   y;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1; e.due = cap + 1;
    end else begin
      if (s) begin
        x = $signed(a);
        y = $signed(b);
      end else begin
        x = {24'd0, a};
        y = {24'd0, b};
      end
      e.q = 8'(x / y); e.r = 8'(x % y); e.dz = 1'b0; e.due = cap + 9;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got DONE=1 expected DONE=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", o_quotient, e.q);
        chk("remainder", o_remainder, e.r);
        chk("div_zero", o_div_zero, e.dz);
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", o_busy, 0);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; d1 = a; d2 = b; sop = s;
    sb.push_back(model(a, b, s, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_capture", o_busy, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no DONE expected %0d pending results", sb.size());
      sb.delete();
    end
  endtask

  vec_t dir[10] = '{
    '{8'd100, 8'd7,  1'b1},
    '{8'h9C,  8'h07, 1'b1},
    '{8'hC8,  8'h07, 1'b0},
    '{8'hC8,  8'h07, 1'b1},
    '{8'h35,  8'h00, 1'b1},
    '{8'd9,   8'd3,  1'b1},
    '{8'h80,  8'hFF, 1'b1},
    '{8'd0,   8'd5,  1'b1},
    '{8'd5,   8'd9,  1'b1},
    '{8'hF9,  8'h02, 1'b1}
  };

  initial begin
    int n0;
    logic [7:0] ra;
    logic [7:0] rb;

    #1;
    chk("rst_quotient", o_quotient, 0);
    chk("rst_remainder", o_remainder, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_div_zero", o_div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, dir[i].s);
      drain();
    end

    // START pulsed while busy must be dropped, not queued.
    issue(8'd77, 8'd4, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; d1 = 8'd50; d2 = 8'd6;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // START held across DONE: second capture lands on the edge after DONE.
    @(negedge clk);
    n0 = cyc;
    start = 1'b1; d1 = 8'd100; d2 = 8'd7; sop = 1'b1;
    sb.push_back(model(8'd100, 8'd7, 1'b1, n0 + 1));
    sb.push_back(model(8'd20, 8'd3, 1'b1, n0 + 11));
    @(negedge clk);
    d1 = 8'd20; d2 = 8'd3;
    while (cyc < n0 + 11) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Reset mid-CALC discards the operation.
    issue(8'd100, 8'd7, 1'b1);
    repeat (2) @(negedge clk);
    chk("busy_mid_calc", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_quotient", o_quotient, 0);
    chk("arst_remainder", o_remainder, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    chk("arst_div_zero", o_div_zero, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd20, 8'd3, 1'b1);
    drain();

    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)));
      drain();
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
